// File: rtl/ternary_tree_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ternary_tree_pkg
// Brief    : Shared constants and state encoding for the ternary tree feeder.
// Revision : 1.0 - initial release
// ============================================================================
package ternary_tree_pkg;

    localparam int LAT   = 2;   // adder tree latency, issue to sum
    localparam int N_OPS = 5;   // operands per group (A..E)

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        ISSUE_ABC = 2'd1,
        ISSUE_DE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ternary_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ternary_result_fifo
// Brief    : Synchronous show-ahead FIFO holding returned tree sums.
// Revision : 1.0 - initial release
// ============================================================================
module ternary_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] WR_DATA,
    input  logic             RD_EN,
    output logic [WIDTH-1:0] RD_DATA,
    output logic             FULL,
    output logic             EMPTY
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign EMPTY     = (r_count == '0);
    assign FULL      = (r_count == c_CNT_W'(DEPTH));
    assign RD_DATA   = r_mem[r_rd_ptr];
    assign w_do_pop  = RD_EN && !EMPTY;
    assign w_do_push = WR_EN && (!FULL || w_do_pop);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= WR_DATA;
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ternary_tree_feeder.sv
`default_nettype none
// ============================================================================
// Module   : ternary_tree_feeder
// Brief    : Collects 5-word groups, drives a 2-stage ternary adder tree with
//            the required A/B/C then D/E skew, and credits its result FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ternary_tree_feeder
    import ternary_tree_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] TREE_A,
    output logic [WIDTH-1:0] TREE_B,
    output logic [WIDTH-1:0] TREE_C,
    output logic [WIDTH-1:0] TREE_D,
    output logic [WIDTH-1:0] TREE_E,
    input  logic [WIDTH-1:0] TREE_SUM,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int c_CRED_W = $clog2(DEPTH + 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [2:0]          r_cnt;
    logic [WIDTH-1:0]    r_buf [N_OPS];
    logic [c_CRED_W-1:0] r_credits;
    logic [LAT-1:0]      r_pipe;
    logic                r_run;     // keeps IN_READY low while in reset

    logic                w_accept;
    logic                w_issue;
    logic                w_pop;
    logic                w_push;
    logic                w_empty;
    logic                w_full;
    logic [WIDTH-1:0]    w_head;

    assign IN_READY  = r_run && (r_cnt < 3'(N_OPS));
    assign w_accept  = IN_VALID && IN_READY;
    assign w_issue   = (r_state == ISSUE_ABC) && (r_credits != '0);
    assign w_push    = r_pipe[LAT-1];
    assign OUT_VALID = !w_empty;
    assign OUT_DATA  = w_head;
    assign w_pop     = OUT_VALID && OUT_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ISSUE_ABC doubles as "group complete, waiting for a credit"
    always_comb begin
        w_next_state = r_state;
        TREE_A = '0;
        TREE_B = '0;
        TREE_C = '0;
        TREE_D = '0;
        TREE_E = '0;
        unique case (r_state)
            COLLECT: begin
                if (w_accept && (r_cnt == 3'(N_OPS - 1))) w_next_state = ISSUE_ABC;
            end
            ISSUE_ABC: begin
                if (w_issue) begin
                    TREE_A = r_buf[0];
                    TREE_B = r_buf[1];
                    TREE_C = r_buf[2];
                    w_next_state = ISSUE_DE;
                end
            end
            ISSUE_DE: begin
                TREE_D = r_buf[3];
                TREE_E = r_buf[4];
                w_next_state = COLLECT;
            end
            default: w_next_state = COLLECT;
        endcase
    end

    // Slots 3/4 stay intact through ISSUE_DE since new words land at slot 0
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_run     <= 1'b0;
            r_cnt     <= '0;
            r_credits <= c_CRED_W'(DEPTH);
            r_pipe    <= '0;
            for (int i = 0; i < N_OPS; i++) r_buf[i] <= '0;
        end else begin
            r_run  <= 1'b1;
            r_pipe <= {r_pipe[LAT-2:0], w_issue};
            if (w_accept) begin
                r_buf[r_cnt] <= IN_DATA;
            end
            if (w_issue) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_issue && !w_pop) begin
                r_credits <= r_credits - 1'b1;
            end else if (w_pop && !w_issue) begin
                r_credits <= r_credits + 1'b1;
            end
        end
    end

    ternary_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .WR_EN   (w_push),
        .WR_DATA (TREE_SUM),
        .RD_EN   (w_pop),
        .RD_DATA (w_head),
        .FULL    (w_full),
        .EMPTY   (w_empty)
    );

    a_credit_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
        (w_pop && !w_issue) |-> (r_credits < c_CRED_W'(DEPTH)));

    a_push_when_full: assert property (@(posedge CLK) disable iff (!RST_N)
        (w_push && !w_pop) |-> !w_full);

endmodule
`default_nettype wire

// File: tb/tb_ternary_tree_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ternary_tree_feeder
// Brief    : Directed self-checking bench; includes a 2-stage tree model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ternary_tree_feeder;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic [WIDTH-1:0] IN_DATA;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] TREE_A, TREE_B, TREE_C, TREE_D, TREE_E;
    logic [WIDTH-1:0] TREE_SUM;
    logic [WIDTH-1:0] OUT_DATA;
    logic             OUT_VALID;
    logic             OUT_READY;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    // Tree model: registers A+B+C, then adds D+E one stage later (unreset)
    logic [WIDTH-1:0] r_stage1;
    always @(posedge CLK) begin
        r_stage1 <= TREE_A + TREE_B + TREE_C;
        TREE_SUM <= r_stage1 + TREE_D + TREE_E;
    end

    ternary_tree_feeder #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .TREE_A    (TREE_A),
        .TREE_B    (TREE_B),
        .TREE_C    (TREE_C),
        .TREE_D    (TREE_D),
        .TREE_E    (TREE_E),
        .TREE_SUM  (TREE_SUM),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns #1 into the cycle after the word was accepted
    task automatic send_word(input logic [WIDTH-1:0] d);
        int n = 0;
        IN_DATA  = d;
        IN_VALID = 1'b1;
        while (!IN_READY && n < 100) begin
            tick();
            n++;
        end
        if (!IN_READY) begin
            checks++;
            errors++;
            $display("FAIL send_word_timeout: IN_READY=%b required 1", IN_READY);
        end
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic send_group(input logic [WIDTH-1:0] d);
        for (int i = 0; i < 5; i++) send_word(d);
    endtask

    task automatic test_reset();
        RST_N = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0;
        tick(); tick();
        checks++;
        if (IN_READY !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0", IN_READY);
        end
        checks++;
        if (OUT_VALID !== 1'b0 || OUT_DATA !== 16'd0) begin
            errors++; $display("FAIL reset_out: valid=%b data=%h want 0/0000", OUT_VALID, OUT_DATA);
        end
        checks++;
        if ({TREE_A, TREE_B, TREE_C, TREE_D, TREE_E} !== 80'd0) begin
            errors++; $display("FAIL reset_tree: got %h %h %h %h %h want all 0",
                               TREE_A, TREE_B, TREE_C, TREE_D, TREE_E);
        end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        OUT_READY = 1'b1;
        for (int i = 1; i <= 5; i++) send_word(16'(i));
        checks++;
        if ({TREE_A, TREE_B, TREE_C, TREE_D, TREE_E} !== {16'd1, 16'd2, 16'd3, 16'd0, 16'd0}
            || IN_READY !== 1'b0) begin
            errors++; $display("FAIL basic_abc: got %h %h %h %h %h rdy=%b want 1 2 3 0 0 rdy=0",
                               TREE_A, TREE_B, TREE_C, TREE_D, TREE_E, IN_READY);
        end
        tick();
        checks++;
        if ({TREE_A, TREE_B, TREE_C, TREE_D, TREE_E} !== {16'd0, 16'd0, 16'd0, 16'd4, 16'd5}
            || IN_READY !== 1'b1) begin
            errors++; $display("FAIL basic_de: got %h %h %h %h %h rdy=%b want 0 0 0 4 5 rdy=1",
                               TREE_A, TREE_B, TREE_C, TREE_D, TREE_E, IN_READY);
        end
        tick();
        checks++;
        if (OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL basic_early_valid: got %b want 0 at t+2", OUT_VALID);
        end
        tick();
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'd15) begin
            errors++; $display("FAIL basic_sum: valid=%b data=%0d want 1/15", OUT_VALID, OUT_DATA);
        end
        tick();
        checks++;
        if (OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL basic_pop: valid=%b want 0 after pop", OUT_VALID);
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        OUT_READY = 1'b1;
        send_group(16'hFFFF);
        while (!OUT_VALID && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'hFFFB) begin
            errors++; $display("FAIL wrap_sum: valid=%b data=%h want 1/fffb", OUT_VALID, OUT_DATA);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int k = 1;
        bit bad = 0;
        OUT_READY = 1'b0;
        for (int g = 1; g <= 5; g++) send_group(16'(2 * g));
        for (int i = 0; i < 6; i++) begin
            if ({TREE_A, TREE_B, TREE_C, TREE_D, TREE_E} !== 80'd0 || IN_READY !== 1'b0) bad = 1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL bp_hold: tree driven or IN_READY=%b while out of credits (want 0)", IN_READY);
        end
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'd10) begin
            errors++; $display("FAIL bp_head: valid=%b data=%0d want 1/10", OUT_VALID, OUT_DATA);
        end
        OUT_READY = 1'b1;
        for (int c = 0; c < 60 && k <= 5; c++) begin
            if (OUT_VALID) begin
                checks++;
                if (OUT_DATA !== 16'(10 * k)) begin
                    errors++; $display("FAIL bp_order: got %0d want %0d", OUT_DATA, 10 * k);
                end
                k++;
            end
            tick();
        end
        checks++;
        if (k != 6) begin
            errors++; $display("FAIL bp_count: got %0d results want 5", k - 1);
        end
    endtask

    task automatic test_simul_pop_issue();
        int k = 0;
        bit bad = 0;
        OUT_READY = 1'b0;
        send_group(16'd1);
        send_group(16'd2);
        send_group(16'd3);
        send_group(16'd4);
        // issue of group 4 now, with one credit left; pop in this same cycle
        OUT_READY = 1'b1;
        checks++;
        if (TREE_A !== 16'd4 || OUT_VALID !== 1'b1 || OUT_DATA !== 16'd5) begin
            errors++; $display("FAIL simul_cycle: A=%0d valid=%b data=%0d want 4/1/5", TREE_A, OUT_VALID, OUT_DATA);
        end
        tick();
        OUT_READY = 1'b0;
        send_group(16'd5);
        checks++;
        if (TREE_A !== 16'd5) begin
            errors++; $display("FAIL simul_credit_kept: A=%0d want 5 (issue with one credit)", TREE_A);
        end
        send_group(16'd6);
        for (int i = 0; i < 8; i++) begin
            if ({TREE_A, TREE_B, TREE_C, TREE_D, TREE_E} !== 80'd0 || IN_READY !== 1'b0) bad = 1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL simul_no_credit: issue or IN_READY=1 seen with zero credits (want none)");
        end
        OUT_READY = 1'b1;
        for (int c = 0; c < 60 && k < 5; c++) begin
            if (OUT_VALID) begin
                checks++;
                if (OUT_DATA !== 16'(10 + 5 * k)) begin
                    errors++; $display("FAIL simul_order: got %0d want %0d", OUT_DATA, 10 + 5 * k);
                end
                k++;
            end
            tick();
        end
        checks++;
        if (k != 5) begin
            errors++; $display("FAIL simul_count: got %0d results want 5", k);
        end
    endtask

    task automatic test_reset_mid();
        int nout = 0;
        bit seen = 0;
        logic [WIDTH-1:0] got = '0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) send_word(16'd9);
        RST_N = 1'b0;
        tick(); tick();
        RST_N = 1'b1;
        send_group(16'd1);
        checks++;
        if ({TREE_A, TREE_B, TREE_C} !== {16'd1, 16'd1, 16'd1}) begin
            errors++; $display("FAIL rst_partial_discard: got %0d %0d %0d want 1 1 1", TREE_A, TREE_B, TREE_C);
        end
        tick();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (OUT_VALID !== 1'b0) seen = 1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL rst_inflight: OUT_VALID=1 seen after reset want 0");
        end
        for (int i = 6; i <= 10; i++) send_word(16'(i));
        for (int c = 0; c < 20; c++) begin
            if (OUT_VALID) begin
                nout++;
                got = OUT_DATA;
            end
            tick();
        end
        checks++;
        if (nout != 1 || got !== 16'd40) begin
            errors++; $display("FAIL rst_clean_group: count=%0d data=%0d want 1/40", nout, got);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({TREE_A, TREE_B, TREE_C, TREE_D, TREE_E} !== 80'd0 || OUT_VALID !== 1'b0) begin
                errors++; $display("FAIL idle_cycle%0d: tree=%h %h %h %h %h valid=%b want 0",
                                   i, TREE_A, TREE_B, TREE_C, TREE_D, TREE_E, OUT_VALID);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_simul_pop_issue();
        test_reset_mid();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
